// File: rtl/cv_channel_accum.sv
// FP16 channel accumulator: per-element adder tree over LANES, GROUPS-beat accumulation, bias add.
// Optional build macro CV_CHANNEL_ACCUM_RELU_EN clamps negative results to +0 at the output stage.
module cv_channel_accum #(
   parameter int          DATA_WIDTH = 16,
   parameter int          COL_SIZE   = 10,
   parameter int          LANES      = 4,
   parameter int          GROUPS     = 1,
   parameter logic [15:0] BIAS       = 16'hb06a
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [LANES-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0] in_data,
   input  logic                                          acc_clear,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [COL_SIZE-1:0][DATA_WIDTH-1:0]           out_data
);

   localparam int T  = $clog2(LANES);
   localparam int TR = (T == 0) ? 1 : T;
   localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [GW-1:0] GLAST = GW'(GROUPS - 1);

   // IEEE binary16 add, round-to-nearest-even, subnormals kept, canonical quiet NaN 16'h7e00.
   function automatic logic [15:0] addfp16(input logic [15:0] a, input logic [15:0] b);
      logic        a_nan, b_nan, a_inf, b_inf, sub, rnd;
      logic [15:0] l, s, res;
      logic [5:0]  e, d;
      logic [13:0] ml, ms;
      logic [14:0] sum;
      logic [11:0] rm;
      a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
      b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
      a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
      b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
      res   = 16'h0000;
      if (a_nan || b_nan) begin
         res = 16'h7e00;
      end else if (a_inf && b_inf) begin
         res = (a[15] != b[15]) ? 16'h7e00 : a;
      end else if (a_inf) begin
         res = a;
      end else if (b_inf) begin
         res = b;
      end else begin
         if (a[14:0] >= b[14:0]) begin
            l = a;
            s = b;
         end else begin
            l = b;
            s = a;
         end
         sub = l[15] ^ s[15];
         ml  = {(l[14:10] != 5'd0), l[9:0], 3'b000};
         ms  = {(s[14:10] != 5'd0), s[9:0], 3'b000};
         e   = {1'b0, (l[14:10] == 5'd0) ? 5'd1 : l[14:10]};
         d   = e - {1'b0, (s[14:10] == 5'd0) ? 5'd1 : s[14:10]};
         // right shift with the shifted-out bits jammed into the sticky position
         for (int k = 0; k < 14; k++) begin
            if (6'(k) < d) begin
               ms = {1'b0, ms[13:1]} | {13'd0, ms[0]};
            end
         end
         sum = sub ? ({1'b0, ml} - {1'b0, ms}) : ({1'b0, ml} + {1'b0, ms});
         if (sum[14]) begin
            sum = {1'b0, sum[14:1]} | {14'd0, sum[0]};
            e   = e + 6'd1;
         end else begin
            for (int k = 0; k < 14; k++) begin
               if (!sum[13] && (e > 6'd1)) begin
                  sum = {sum[13:0], 1'b0};
                  e   = e - 6'd1;
               end
            end
         end
         rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
         rm  = {1'b0, sum[13:3]} + {11'd0, rnd};
         if (rm[11]) begin
            rm = {1'b0, rm[11:1]};
            e  = e + 6'd1;
         end
         if (e >= 6'd31) begin
            res = {l[15], 5'h1f, 10'h000};
         end else if (rm == 12'd0) begin
            res = {sub ? 1'b0 : l[15], 15'h0000};
         end else begin
            res = {l[15], rm[10] ? e[4:0] : 5'd0, rm[9:0]};
         end
      end
      return res;
   endfunction

   function automatic logic [15:0] post_fn(input logic [15:0] v);
`ifdef CV_CHANNEL_ACCUM_RELU_EN
      return v[15] ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   logic                                  w_advance;
   logic                                  w_accept;
   logic [15:0]                           w_lvl     [T+1][LANES][COL_SIZE];
   logic                                  w_lvl_vld [T+1];
   logic [15:0]                           r_lvl     [TR][LANES][COL_SIZE];
   logic                                  r_vld     [TR];
   logic [15:0]                           r_acc     [COL_SIZE];
   logic [GW-1:0]                         r_gcnt;
   logic                                  r_acc_done;
   logic                                  r_out_valid;
   logic [COL_SIZE-1:0][DATA_WIDTH-1:0]   r_out_data;

   assign w_advance = !(r_out_valid && !out_ready);
   assign w_accept  = in_valid && w_advance && !acc_clear;
   assign in_ready  = w_advance;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   // Level 0 is the input beat itself; level k>0 is the output of tree register k-1.
   always_comb begin
      for (int k = 0; k <= T; k++) begin
         w_lvl_vld[k] = (k == 0) ? w_accept : r_vld[(k == 0) ? 0 : k - 1];
         for (int j = 0; j < LANES; j++) begin
            for (int c = 0; c < COL_SIZE; c++) begin
               w_lvl[k][j][c] = (k == 0) ? in_data[j][c] : r_lvl[(k == 0) ? 0 : k - 1][j][c];
            end
         end
      end
   end

   // Adder tree registers: each level halves the live lane count by summing adjacent pairs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TR; k++) begin
            r_vld[k] <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
               for (int c = 0; c < COL_SIZE; c++) begin
                  r_lvl[k][j][c] <= 16'h0000;
               end
            end
         end
      end else if (acc_clear) begin
         for (int k = 0; k < TR; k++) begin
            r_vld[k] <= 1'b0;
         end
      end else if (w_advance) begin
         for (int k = 0; k < T; k++) begin
            r_vld[k] <= w_lvl_vld[k];
            if (w_lvl_vld[k]) begin
               for (int j = 0; j < LANES / 2; j++) begin
                  if (j < (LANES >> (k + 1))) begin
                     for (int c = 0; c < COL_SIZE; c++) begin
                        r_lvl[k][j][c] <= addfp16(w_lvl[k][2*j][c], w_lvl[k][2*j+1][c]);
                     end
                  end
               end
            end
         end
      end
   end

   // Group accumulator; r_acc_done flags a finished column waiting for the output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gcnt     <= '0;
         r_acc_done <= 1'b0;
         for (int c = 0; c < COL_SIZE; c++) begin
            r_acc[c] <= 16'h0000;
         end
      end else if (acc_clear) begin
         r_gcnt     <= '0;
         r_acc_done <= 1'b0;
      end else if (w_advance) begin
         r_acc_done <= w_lvl_vld[T] && (r_gcnt == GLAST);
         if (w_lvl_vld[T]) begin
            for (int c = 0; c < COL_SIZE; c++) begin
               r_acc[c] <= (r_gcnt == '0) ? w_lvl[T][0][c] : addfp16(r_acc[c], w_lvl[T][0][c]);
            end
            r_gcnt <= (r_gcnt == GLAST) ? '0 : r_gcnt + GW'(1);
         end
      end
   end

   // Output register: bias add (and optional clamp); untouched by acc_clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_advance) begin
         r_out_valid <= r_acc_done;
         if (r_acc_done) begin
            for (int c = 0; c < COL_SIZE; c++) begin
               r_out_data[c] <= post_fn(addfp16(r_acc[c], BIAS));
            end
         end
      end
   end

endmodule

// File: tb/tb_cv_channel_accum.sv
// Bench for cv_channel_accum: GROUPS=1 and GROUPS=3 instances against a real-arithmetic FP16 model.
module tb_cv_channel_accum;
   localparam int COLS = 10, LANES = 4, T = 2, ND = 2;
   localparam logic [15:0] BIASV = 16'h3C00;
`ifdef CV_CHANNEL_ACCUM_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, in_valid, acc_clear, out_ready;
   logic [LANES-1:0][COLS-1:0][15:0] in_data;
   logic [ND-1:0] in_ready, out_valid;
   logic [COLS-1:0][15:0] out_data [ND];

   cv_channel_accum #(.DATA_WIDTH(16), .COL_SIZE(COLS), .LANES(LANES), .GROUPS(1), .BIAS(BIASV)) u_g1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
      .acc_clear(acc_clear), .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]));
   cv_channel_accum #(.DATA_WIDTH(16), .COL_SIZE(COLS), .LANES(LANES), .GROUPS(3), .BIAS(BIASV)) u_g3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
      .acc_clear(acc_clear), .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]));

   int checks = 0, failures = 0, cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- reference arithmetic: exact real sum, rounded once to FP16 ----------------
   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real h2r(input logic [15:0] h);
      real v;
      int  e = int'(h[14:10]);
      if (e == 0) v = real'(h[9:0]) * pow2(-24);
      else v = (real'(h[9:0]) + 1024.0) * pow2(e - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic longint rne(input real q);
      longint i = longint'($floor(q));
      real    fr = q - real'(i);
      if (fr > 0.5 || (fr == 0.5 && i[0])) i++;
      return i;
   endfunction

   function automatic logic [15:0] r2h(input real v, input logic zsign);
      logic   s;
      real    a;
      int     e;
      longint m;
      if (v == 0.0) return {zsign, 15'h0000};
      s = (v < 0.0);
      a = s ? -v : v;
      if (a < pow2(-14)) begin
         m = rne(a * pow2(24));
         return {s, m[14:0]};
      end
      e = -14;
      while (a >= pow2(e + 1)) e++;
      m = rne(a * pow2(10 - e));
      if (m == 2048) begin
         m = 1024;
         e++;
      end
      if (e > 15) return {s, 5'h1f, 10'h000};
      return {s, 5'(e + 15), m[9:0]};
   endfunction

   function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
      return r2h(h2r(a) + h2r(b), a[15] & b[15]);
   endfunction

   function automatic int grp(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // ---------------- behavioural model: beats tagged by count of advancing clock edges ----------------
   int          adv_n [ND], gcnt [ND], ph [ND], pt [ND];
   logic [15:0] macc  [ND][COLS];
   logic        exp_ov [ND];
   logic [15:0] exp_od [ND][COLS];
   logic [15:0] pv     [ND][16][COLS];
   int          pdue   [ND][16];

   task automatic model_step();
      if (!rst_n) begin
         for (int d = 0; d < ND; d++) begin
            adv_n[d] = 0; gcnt[d] = 0; ph[d] = 0; pt[d] = 0; exp_ov[d] = 1'b0;
            for (int c = 0; c < COLS; c++) exp_od[d][c] = 16'h0000;
         end
      end else begin
         for (int d = 0; d < ND; d++) begin
            logic        adv;
            logic [15:0] tsum;
            adv = !(exp_ov[d] && !out_ready);
            if (adv) begin
               adv_n[d]++;
               if (pt[d] != ph[d] && pdue[d][ph[d] % 16] == adv_n[d]) begin
                  exp_ov[d] = 1'b1;
                  for (int c = 0; c < COLS; c++) exp_od[d][c] = pv[d][ph[d] % 16][c];
                  ph[d]++;
               end else begin
                  exp_ov[d] = 1'b0;
               end
            end
            if (acc_clear) begin
               gcnt[d] = 0;
               while (pt[d] > ph[d] && pdue[d][(pt[d] - 1) % 16] > adv_n[d]) pt[d]--;
            end else if (adv && in_valid) begin
               for (int c = 0; c < COLS; c++) begin
                  tsum = fadd(fadd(in_data[0][c], in_data[1][c]), fadd(in_data[2][c], in_data[3][c]));
                  macc[d][c] = (gcnt[d] == 0) ? tsum : fadd(macc[d][c], tsum);
               end
               if (gcnt[d] == grp(d) - 1) begin
                  for (int c = 0; c < COLS; c++) begin
                     tsum = fadd(macc[d][c], BIASV);
                     pv[d][pt[d] % 16][c] = (RELU && tsum[15]) ? 16'h0000 : tsum;
                  end
                  pdue[d][pt[d] % 16] = adv_n[d] + T + 1;
                  pt[d]++;
               end
               gcnt[d] = (gcnt[d] + 1) % grp(d);
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- compare + output monitor (negedge, away from the active edge) ----------------
   int          hs_cnt [ND], ov_cnt [ND], first_ov [ND];
   logic [15:0] rec [ND][64];

   initial forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("out_valid[g%0d]", grp(d)), 32'(out_valid[d]), 32'(exp_ov[d]));
         chk($sformatf("in_ready[g%0d]", grp(d)), 32'(in_ready[d]), 32'(!(exp_ov[d] && !out_ready)));
         if (exp_ov[d]) begin
            for (int c = 0; c < COLS; c++) begin
               if (out_data[d][c] !== exp_od[d][c]) begin
                  chk($sformatf("out_data[g%0d][%0d]", grp(d), c), 32'(out_data[d][c]), 32'(exp_od[d][c]));
               end
            end
            checks++;
         end
         if (out_valid[d]) begin
            ov_cnt[d]++;
            if (first_ov[d] < 0) first_ov[d] = cyc;
         end
         if (out_valid[d] && out_ready) begin
            if (hs_cnt[d] < 64) rec[d][hs_cnt[d]] = out_data[d][0];
            hs_cnt[d]++;
         end
      end
   end

   // ---------------- stimulus ----------------
   int acc_cyc;

   task automatic clear_stats();
      for (int d = 0; d < ND; d++) begin
         hs_cnt[d] = 0; ov_cnt[d] = 0; first_ov[d] = -1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; acc_clear = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic drive_beat(input logic [15:0] v, input logic clr);
      bit ok;
      ok = 1'b0;
      for (int l = 0; l < LANES; l++) for (int c = 0; c < COLS; c++) in_data[l][c] = v;
      in_valid = 1'b1; acc_clear = clr;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready[0]) begin
            ok = 1'b1;
            acc_cyc = cyc;
         end
         @(posedge clk);
         #1;
         if (ok) break;
      end
      if (!ok) chk("beat_accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0; acc_clear = 1'b0;
   endtask

   function automatic logic [15:0] rnd_h();
      return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 24)), 10'($urandom)};
   endfunction

   logic [15:0] vals [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
   logic [15:0] bp_req [8] = '{16'h4500, 16'h4880, 16'h4A80, 16'h4C40, 16'h4D40, 16'h4E40, 16'h4F40, 16'h5020};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; acc_clear = 1'b0; out_ready = 1'b1; in_data = '0;
      clear_stats();
      idle(2);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
         chk("reset_in_ready", 32'(in_ready[d]), 32'd1);
         chk("reset_out_data_zero", 32'(|out_data[d]), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      // single beat of 1.0, GROUPS=1: 4*1+1 = 5.0, four cycles after acceptance, one cycle wide
      clear_stats();
      drive_beat(16'h3C00, 1'b0);
      idle(8);
      chk("g1_latency", 32'(first_ov[0] - acc_cyc), 32'd4);
      chk("g1_valid_cycles", 32'(ov_cnt[0]), 32'd1);
      chk("g1_value", 32'(rec[0][0]), 32'h4500);

      // three beats of 0.5, GROUPS=3: 3*(4*0.5)+1 = 7.0 once
      do_reset(); clear_stats();
      for (int i = 0; i < 3; i++) drive_beat(16'h3800, 1'b0);
      idle(8);
      chk("g3_count", 32'(hs_cnt[1]), 32'd1);
      chk("g3_value", 32'(rec[1][0]), 32'h4700);
      chk("g3_latency", 32'(first_ov[1] - acc_cyc), 32'd4);
      chk("g3_sibling_g1_count", 32'(hs_cnt[0]), 32'd3);
      chk("g3_sibling_g1_value", 32'(rec[0][2]), 32'h4200);

      // backpressure: 8 beats 1.0..8.0, out_ready low for 5 cycles from the first result
      do_reset(); clear_stats();
      fork
         begin
            for (int i = 0; i < 8; i++) drive_beat(vals[i], 1'b0);
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
               @(posedge clk); #1;
               if (out_valid[0]) seen = 1'b1;
            end
            if (!seen) chk("bp_wait_timeout", 32'd0, 32'd1);
            else begin
               out_ready = 1'b0;
               repeat (5) begin
                  @(negedge clk);
                  chk("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
                  chk("bp_data_stable", 32'(out_data[0][0]), 32'h4500);
               end
               @(posedge clk); #1;
               out_ready = 1'b1;
            end
         end
      join
      idle(12);
      chk("bp_count", 32'(hs_cnt[0]), 32'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("bp_result%0d", i), 32'(rec[0][i]), 32'(bp_req[i]));

      // reset mid-group discards the partial sum
      do_reset(); clear_stats();
      drive_beat(16'h3800, 1'b0);
      drive_beat(16'h3800, 1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) drive_beat(16'h3800, 1'b0);
      idle(8);
      chk("rst_mid_count", 32'(hs_cnt[1]), 32'd1);
      chk("rst_mid_value", 32'(rec[1][0]), 32'h4700);

      // acc_clear together with beat 2 drops both beats so far
      do_reset(); clear_stats();
      drive_beat(16'h3800, 1'b0);
      drive_beat(16'h3800, 1'b1);
      for (int i = 0; i < 3; i++) drive_beat(16'h3800, 1'b0);
      idle(8);
      chk("clr_count", 32'(hs_cnt[1]), 32'd1);
      chk("clr_value", 32'(rec[1][0]), 32'h4700);

      // negative result: 4*(-1)+1 = -3.0
      do_reset(); clear_stats();
      drive_beat(16'hBC00, 1'b0);
      idle(8);
      chk("neg_value", 32'(rec[0][0]), RELU ? 32'h0000 : 32'hC200);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         acc_clear = ($urandom_range(0, 39) == 0);
         rst_n     = ($urandom_range(0, 499) != 0);
         for (int l = 0; l < LANES; l++) for (int c = 0; c < COLS; c++) in_data[l][c] = rnd_h();
         @(posedge clk); #1;
      end
      rst_n = 1'b1; in_valid = 1'b0; acc_clear = 1'b0; out_ready = 1'b1;
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
